mem_stage: RTL and testbench

//  MEM pipeline stage, directly downstream of EX. Accepts one EX result per handshake.

---
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage that runs data-memory loads/stores over a req/ack bus,
// resolves branches and raises alignment, overflow and bus-timeout exceptions.
//   clk, nrst                  clock, synchronous active-low reset
//   i_valid / o_ready          EX handshake; ready only while no access is outstanding
//   i_MEM_*, i_WB_*            EX result and control fields, latched on accept
//   o_dmem_*, i_dmem_*         data-memory request bus
//   o_IF_*                     branch redirect pulse and target
//   o_WB_*                     registered WB-stage fields, valid with o_WB_valid
//   o_exc_*                    exception pulses, aligned with o_WB_valid
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_MEM_data_PCBranch,
   input  logic [31:0] i_MEM_data_ALUOut,
   input  logic        i_MEM_data_Zero,
   input  logic        i_MEM_data_Overflow,
   input  logic [31:0] i_MEM_data_RTData,
   input  logic [31:0] i_WB_data_RegAddrW,
   input  logic        i_MEM_ctrl_MemWrite,
   input  logic        i_MEM_ctrl_MemRead,
   input  logic        i_MEM_ctrl_Branch,
   input  logic        i_WB_ctrl_Mem2Reg,
   input  logic        i_WB_ctrl_RegWrite,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_IF_ctrl_PCSrc,
   output logic [31:0] o_IF_data_PCBranch,
   output logic        o_WB_valid,
   output logic [31:0] o_WB_data_MemData,
   output logic [31:0] o_WB_data_ALUOut,
   output logic [4:0]  o_WB_data_RegAddrW,
   output logic        o_WB_ctrl_Mem2Reg,
   output logic        o_WB_ctrl_RegWrite,
   output logic        o_exc_overflow,
   output logic        o_exc_addr,
   output logic        o_exc_buserr
);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t     state_q;
   logic [7:0] cnt_q;
   logic       rw_q, ovf_q;
   logic       acc_d, mem_d, mis_d, tmo_d;
   assign o_ready = state_q == IDLE;
   assign acc_d   = i_valid & o_ready;
   // branch ops never touch memory, even if a memory strobe is also set
   assign mem_d   = (i_MEM_ctrl_MemWrite | i_MEM_ctrl_MemRead) & ~i_MEM_ctrl_Branch;
   assign mis_d   = i_MEM_data_ALUOut[1:0] != 2'b00;
   assign tmo_d   = cnt_q == 8'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         rw_q               <= 1'b0;
         ovf_q              <= 1'b0;
         o_dmem_req         <= 1'b0;
         o_dmem_we          <= 1'b0;
         o_dmem_addr        <= '0;
         o_dmem_wdata       <= '0;
         o_IF_ctrl_PCSrc    <= 1'b0;
         o_IF_data_PCBranch <= '0;
         o_WB_valid         <= 1'b0;
         o_WB_data_MemData  <= '0;
         o_WB_data_ALUOut   <= '0;
         o_WB_data_RegAddrW <= '0;
         o_WB_ctrl_Mem2Reg  <= 1'b0;
         o_WB_ctrl_RegWrite <= 1'b0;
         o_exc_overflow     <= 1'b0;
         o_exc_addr         <= 1'b0;
         o_exc_buserr       <= 1'b0;
      end else begin
         o_WB_valid      <= 1'b0;
         o_IF_ctrl_PCSrc <= 1'b0;
         o_exc_overflow  <= 1'b0;
         o_exc_addr      <= 1'b0;
         o_exc_buserr    <= 1'b0;
         if (acc_d) begin
            o_WB_data_ALUOut   <= i_MEM_data_ALUOut;
            o_WB_data_RegAddrW <= i_WB_data_RegAddrW[4:0];
            o_WB_ctrl_Mem2Reg  <= i_WB_ctrl_Mem2Reg;
            o_WB_data_MemData  <= '0;
            o_IF_data_PCBranch <= i_MEM_data_PCBranch;
            o_dmem_we          <= i_MEM_ctrl_MemWrite;
            o_dmem_addr        <= {i_MEM_data_ALUOut[31:2], 2'b00};
            o_dmem_wdata       <= i_MEM_data_RTData;
            rw_q               <= i_WB_ctrl_RegWrite & ~i_MEM_data_Overflow;
            ovf_q              <= i_MEM_data_Overflow & i_WB_ctrl_RegWrite;
            if (mem_d & ~mis_d) begin
               state_q    <= ACCESS;
               cnt_q      <= '0;
               o_dmem_req <= 1'b1;
            end else begin
               o_WB_valid         <= 1'b1;
               o_WB_ctrl_RegWrite <= i_WB_ctrl_RegWrite & ~i_MEM_data_Overflow & ~mem_d;
               o_exc_addr         <= mem_d;
               o_exc_overflow     <= i_MEM_data_Overflow & i_WB_ctrl_RegWrite;
               o_IF_ctrl_PCSrc    <= i_MEM_ctrl_Branch & i_MEM_data_Zero;
            end
         end
         if (state_q == ACCESS) begin
            // an ack in the limit cycle completes normally instead of erroring
            if (i_dmem_ack | tmo_d) begin
               state_q            <= IDLE;
               o_dmem_req         <= 1'b0;
               o_WB_valid         <= 1'b1;
               o_exc_overflow     <= ovf_q;
               o_exc_buserr       <= ~i_dmem_ack;
               o_WB_ctrl_RegWrite <= rw_q & i_dmem_ack;
               o_WB_data_MemData  <= (i_dmem_ack & ~o_dmem_we) ? i_dmem_rdata : '0;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level model.
module tb_mem_stage;
   localparam int T = 4;
   logic        clk = 1'b0, nrst = 1'b0, i_valid = 1'b0, o_ready;
   logic [31:0] i_MEM_data_PCBranch = '0, i_MEM_data_ALUOut = '0, i_MEM_data_RTData = '0, i_WB_data_RegAddrW = '0;
   logic        i_MEM_data_Zero = 1'b0, i_MEM_data_Overflow = 1'b0;
   logic        i_MEM_ctrl_MemWrite = 1'b0, i_MEM_ctrl_MemRead = 1'b0, i_MEM_ctrl_Branch = 1'b0;
   logic        i_WB_ctrl_Mem2Reg = 1'b0, i_WB_ctrl_RegWrite = 1'b0;
   logic        o_dmem_req, o_dmem_we, i_dmem_ack = 1'b0;
   logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata = '0;
   logic        o_IF_ctrl_PCSrc, o_WB_valid, o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite;
   logic [31:0] o_IF_data_PCBranch, o_WB_data_MemData, o_WB_data_ALUOut;
   logic [4:0]  o_WB_data_RegAddrW;
   logic        o_exc_overflow, o_exc_addr, o_exc_buserr;
   int checks = 0, errors = 0;

   mem_stage #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .nrst(nrst), .i_valid(i_valid), .o_ready(o_ready),
      .i_MEM_data_PCBranch(i_MEM_data_PCBranch), .i_MEM_data_ALUOut(i_MEM_data_ALUOut),
      .i_MEM_data_Zero(i_MEM_data_Zero), .i_MEM_data_Overflow(i_MEM_data_Overflow),
      .i_MEM_data_RTData(i_MEM_data_RTData), .i_WB_data_RegAddrW(i_WB_data_RegAddrW),
      .i_MEM_ctrl_MemWrite(i_MEM_ctrl_MemWrite), .i_MEM_ctrl_MemRead(i_MEM_ctrl_MemRead),
      .i_MEM_ctrl_Branch(i_MEM_ctrl_Branch), .i_WB_ctrl_Mem2Reg(i_WB_ctrl_Mem2Reg),
      .i_WB_ctrl_RegWrite(i_WB_ctrl_RegWrite), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
      .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
      .i_dmem_rdata(i_dmem_rdata), .o_IF_ctrl_PCSrc(o_IF_ctrl_PCSrc),
      .o_IF_data_PCBranch(o_IF_data_PCBranch), .o_WB_valid(o_WB_valid),
      .o_WB_data_MemData(o_WB_data_MemData), .o_WB_data_ALUOut(o_WB_data_ALUOut),
      .o_WB_data_RegAddrW(o_WB_data_RegAddrW), .o_WB_ctrl_Mem2Reg(o_WB_ctrl_Mem2Reg),
      .o_WB_ctrl_RegWrite(o_WB_ctrl_RegWrite), .o_exc_overflow(o_exc_overflow),
      .o_exc_addr(o_exc_addr), .o_exc_buserr(o_exc_buserr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic [31:0] alu, pcb, rt, ra, input logic mw, mr, br, z, ov, m2r, rw);
      i_MEM_data_ALUOut = alu;
      i_MEM_data_PCBranch = pcb;
      i_MEM_data_RTData = rt;
      i_WB_data_RegAddrW = ra;
      i_MEM_ctrl_MemWrite = mw;
      i_MEM_ctrl_MemRead = mr;
      i_MEM_ctrl_Branch = br;
      i_MEM_data_Zero = z;
      i_MEM_data_Overflow = ov;
      i_WB_ctrl_Mem2Reg = m2r;
      i_WB_ctrl_RegWrite = rw;
   endtask

   // d = ACCESS cycle in which the bus acks (0 = never); rd = load data returned with the ack
   task automatic exec(input int d, input logic [31:0] rd);
      logic mem, ok, tmo, done;
      int   req_exp, reqs;
      mem = (i_MEM_ctrl_MemWrite || i_MEM_ctrl_MemRead) && !i_MEM_ctrl_Branch;
      ok = mem && i_MEM_data_ALUOut[1:0] == 2'b00;
      tmo = ok && (d == 0 || d > T);
      req_exp = !ok ? 0 : tmo ? T : d;
      @(negedge clk);
      chk("ready_idle", 32'(o_ready), 32'd1);
      i_valid = 1'b1;
      i_dmem_ack = 1'($urandom_range(0, 1));
      i_dmem_rdata = $urandom;
      reqs = 0;
      done = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge clk);
         i_valid = 1'b0;
         i_dmem_ack = 1'b0;
         i_dmem_rdata = $urandom;
         if (o_WB_valid) begin
            done = 1'b1;
            chk("latency", 32'(k), 32'(req_exp + 1));
            chk("req_cycles", 32'(reqs), 32'(req_exp));
            chk("req_dropped", 32'(o_dmem_req), 32'd0);
            chk("ready_after", 32'(o_ready), 32'd1);
            chk("wb_aluout", o_WB_data_ALUOut, i_MEM_data_ALUOut);
            chk("wb_regaddr", 32'(o_WB_data_RegAddrW), 32'(i_WB_data_RegAddrW[4:0]));
            chk("wb_mem2reg", 32'(o_WB_ctrl_Mem2Reg), 32'(i_WB_ctrl_Mem2Reg));
            chk("wb_regwrite", 32'(o_WB_ctrl_RegWrite),
                32'(i_WB_ctrl_RegWrite && !i_MEM_data_Overflow && !(mem && (!ok || tmo))));
            chk("wb_memdata", o_WB_data_MemData, (ok && !tmo && !i_MEM_ctrl_MemWrite) ? rd : 32'd0);
            chk("exc_addr", 32'(o_exc_addr), 32'(mem && !ok));
            chk("exc_buserr", 32'(o_exc_buserr), 32'(tmo));
            chk("exc_overflow", 32'(o_exc_overflow), 32'(i_MEM_data_Overflow && i_WB_ctrl_RegWrite));
            chk("pcsrc", 32'(o_IF_ctrl_PCSrc), 32'(i_MEM_ctrl_Branch && i_MEM_data_Zero));
            if (o_IF_ctrl_PCSrc) chk("pcbranch", o_IF_data_PCBranch, i_MEM_data_PCBranch);
         end else begin
            chk("stray_pulse", 32'({o_IF_ctrl_PCSrc, o_exc_overflow, o_exc_addr, o_exc_buserr}), 32'd0);
            if (o_dmem_req) begin
               reqs++;
               chk("ready_busy", 32'(o_ready), 32'd0);
               chk("dmem_we", 32'(o_dmem_we), 32'(i_MEM_ctrl_MemWrite));
               chk("dmem_addr", o_dmem_addr, {i_MEM_data_ALUOut[31:2], 2'b00});
               chk("dmem_wdata", o_dmem_wdata, i_MEM_data_RTData);
               if (reqs == d) begin
                  i_dmem_ack = 1'b1;
                  i_dmem_rdata = rd;
               end
            end
         end
      end
      if (!done) chk("wb_never_seen", 32'd0, 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_req", 32'(o_dmem_req), 32'd0);
      chk("rst_wbvalid", 32'(o_WB_valid), 32'd0);
      chk("rst_aluout", o_WB_data_ALUOut, 32'd0);
      chk("rst_pcsrc", 32'(o_IF_ctrl_PCSrc), 32'd0);
      nrst = 1'b1;
      set_op(32'h1234, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
      exec(0, 0);
      set_op(32'h100, 0, 0, 7, 0, 1, 0, 0, 0, 1, 1);
      exec(3, 32'hDEADBEEF);
      set_op(32'h102, 0, 32'h55, 3, 1, 0, 0, 0, 0, 0, 0);
      exec(1, 0);
      set_op(32'h200, 0, 0, 9, 0, 1, 0, 0, 0, 1, 1);
      exec(0, 32'h1111);
      set_op(32'h204, 0, 0, 9, 0, 1, 0, 0, 0, 1, 1);
      exec(T, 32'hCAFEF00D);
      set_op(32'h300, 0, 32'hA5A5, 2, 1, 1, 0, 0, 0, 0, 0);
      exec(2, 32'h9999);
      set_op(32'h0, 32'h40, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      exec(0, 0);
      set_op(32'h4, 32'h40, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      exec(0, 0);
      set_op(32'h7FFF0000, 0, 0, 4, 0, 0, 0, 0, 1, 0, 1);
      exec(0, 0);
      // back-to-back ALU ops give one WB pulse per cycle
      @(negedge clk);
      set_op(32'hA1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      i_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready", 32'(o_ready), 32'd1);
      chk("b2b_wb1", 32'(o_WB_valid), 32'd1);
      chk("b2b_alu1", o_WB_data_ALUOut, 32'hA1);
      set_op(32'hB2, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      i_valid = 1'b0;
      chk("b2b_wb2", 32'(o_WB_valid), 32'd1);
      chk("b2b_alu2", o_WB_data_ALUOut, 32'hB2);
      @(negedge clk);
      chk("b2b_idle", 32'(o_WB_valid), 32'd0);
      // reset in the 2nd ACCESS cycle aborts the load silently
      set_op(32'h400, 0, 0, 6, 0, 1, 0, 0, 0, 1, 1);
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      chk("abort_req_on", 32'(o_dmem_req), 32'd1);
      nrst = 1'b0;
      @(negedge clk);
      chk("abort_req_off", 32'(o_dmem_req), 32'd0);
      chk("abort_wb", 32'(o_WB_valid), 32'd0);
      nrst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_wb", 32'(o_WB_valid), 32'd0);
      end
      set_op(32'h5678, 0, 0, 12, 0, 0, 0, 0, 0, 0, 1);
      exec(0, 0);
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         set_op(a, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom));
         exec(int'($urandom_range(0, T + 2)), $urandom);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
